// File: rtl/ddr3_burst_checker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ddr3_burst_checker_if : read half of the DDRAM Avalon port                 |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface ddr3_burst_checker_if;
  logic        ddram_rd;
  logic [28:0] ddram_addr;
  logic [7:0]  ddram_burstcnt;
  logic        ddram_busy;
  logic [63:0] ddram_dout;
  logic        ddram_dout_ready;

  modport master (
    output ddram_rd, ddram_addr, ddram_burstcnt,
    input  ddram_busy, ddram_dout, ddram_dout_ready
  );

  modport slave (
    input  ddram_rd, ddram_addr, ddram_burstcnt,
    output ddram_busy, ddram_dout, ddram_dout_ready
  );
endinterface
`default_nettype wire

// File: rtl/ddr3_burst_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ddr3_burst_checker : reads back one DDR3 burst and checks beat==index      |
// | Optional: DDR3_BURST_LATENCY_EN adds the request-to-first-beat counter.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module ddr3_burst_checker #(
  parameter int unsigned BURST_LEN = 128,
  parameter logic [28:0] BASE_ADDR = 29'h2400000,
  parameter logic [63:0] CMP_MASK  = 64'hFFFFFFFF,
  parameter int unsigned TIMEOUT   = 4096
) (
  input  wire                  clk_ddr3,
  input  wire                  reset,
  input  wire                  start,
  ddr3_burst_checker_if.master ddram,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [7:0]           err_cnt,
  output logic [7:0]           first_err_idx
`ifdef DDR3_BURST_LATENCY_EN
  ,
  output logic [15:0]          latency
`endif
);

  localparam int unsigned      GAP_W     = $clog2(TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT - 1);
  localparam logic [7:0]       LAST_BEAT = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       beat_idx_q, beat_idx_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [7:0]       first_q, first_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;
  logic             w_clear;
  logic             w_mismatch;
`ifdef DDR3_BURST_LATENCY_EN
  logic [15:0]      latency_q, latency_d;
`endif

  assign w_clear    = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
  assign w_mismatch = |((ddram.ddram_dout ^ {56'b0, beat_idx_q}) & CMP_MASK);

  always_comb begin
    state_d    = state_q;
    beat_idx_d = beat_idx_q;
    err_cnt_d  = err_cnt_q;
    first_d    = first_q;
    gap_d      = gap_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (w_clear) begin
          state_d    = S_REQ;
          beat_idx_d = 8'd0;
          err_cnt_d  = 8'd0;
          first_d    = 8'hFF;
          gap_d      = '0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      S_REQ: begin
        if (!ddram.ddram_busy) begin
          state_d = S_DATA;
          gap_d   = '0;
        end
      end
      S_DATA: begin
        // A beat arriving in the same cycle the gap expires wins over the timeout.
        if (ddram.ddram_dout_ready) begin
          gap_d      = '0;
          beat_idx_d = beat_idx_q + 8'd1;
          if (w_mismatch) begin
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            if (first_q == 8'hFF)   first_d   = beat_idx_q;
          end
          if (beat_idx_q == LAST_BEAT) begin
            state_d = S_DONE;
            pass_d  = (err_cnt_d == 8'd0);
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
          if (gap_q == GAP_LAST) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
            pass_d    = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef DDR3_BURST_LATENCY_EN
    latency_d = latency_q;
    if (w_clear) begin
      latency_d = 16'd0;
    end else if ((state_q == S_DATA) && (beat_idx_q == 8'd0)) begin
      if (timeout_d)                latency_d = 16'hFFFF;
      else if (latency_q != 16'hFFFF) latency_d = latency_q + 16'd1;
    end
`endif
  end

  always_ff @(posedge clk_ddr3 or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      beat_idx_q <= 8'd0;
      err_cnt_q  <= 8'd0;
      first_q    <= 8'hFF;
      gap_q      <= '0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_idx_q <= beat_idx_d;
      err_cnt_q  <= err_cnt_d;
      first_q    <= first_d;
      gap_q      <= gap_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef DDR3_BURST_LATENCY_EN
  always_ff @(posedge clk_ddr3 or posedge reset) begin
    if (reset) latency_q <= 16'd0;
    else       latency_q <= latency_d;
  end

  assign latency = latency_q;
`endif

  assign ddram.ddram_rd       = (state_q == S_REQ);
  assign ddram.ddram_addr     = BASE_ADDR;
  assign ddram.ddram_burstcnt = 8'(BURST_LEN);

  assign busy          = (state_q == S_REQ) || (state_q == S_DATA);
  assign done          = (state_q == S_DONE);
  assign pass          = pass_q;
  assign timeout       = timeout_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_q;

endmodule
`default_nettype wire
